sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 Sobel filter datapath.
- On `start`: streams one RGB444 frame in raster order from the source frame buffer, builds 3x3 windows with two line buffers and drives the filter's 108-bit `color_data` bus.
- Tracks the filter's fixed pipeline latency and writes each result to the destination frame buffer.
- Writes black (0x000) to the one-pixel border. Sits between the frame-buffer RAMs and a `sobel_x`/`sobel_y` instance.

---
 rtl/sobel_frame_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel datapath: streams a frame, builds windows with two line
// buffers, aligns filter results to their centre addresses and blacks out the border.
module sobel_frame_ctrl #(
   parameter int unsigned WIDTH      = 640,
   parameter int unsigned HEIGHT     = 480,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned FILTER_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [11:0]       rd_data,
   output logic [107:0]      color_data,
   input  logic [11:0]       filter_rgb_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned RW = $clog2(HEIGHT);
   localparam int unsigned DW = $clog2(FILTER_LAT + 2);

   typedef enum logic [2:0] {StIdle, StStream, StDrain, StBorder, StDone} state_e;
   typedef enum logic [1:0] {BdTop, BdBottom, BdSide} bphase_e;

   state_e            state_q;
   bphase_e           bphase_q;
   logic              bside_q;
   logic [RW-1:0]     r_q;
   logic [CW-1:0]     c_q;
   logic [DW-1:0]     drain_q;
   logic [ADDR_W-1:0] rd_addr_q, baddr_q;
   logic              rd_en_q, busy_q, done_q;

   logic              pix_vld_q;
   logic [RW-1:0]     pix_r_q;
   logic [CW-1:0]     pix_c_q;
   logic [ADDR_W-1:0] pix_addr_q;
   logic [11:0]       win_q [3][3];
   logic              win_vld_q;
   logic [ADDR_W-1:0] win_addr_q;
   logic              dly_vld_q  [FILTER_LAT];
   logic [ADDR_W-1:0] dly_addr_q [FILTER_LAT];
   logic [11:0]       lb0 [WIDTH];
   logic [11:0]       lb1 [WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         bphase_q  <= BdTop;
         bside_q   <= 1'b0;
         r_q       <= '0;
         c_q       <= '0;
         drain_q   <= '0;
         rd_addr_q <= '0;
         baddr_q   <= '0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= StStream;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  r_q       <= '0;
                  c_q       <= '0;
               end
            end
            StStream: begin
               if (r_q == RW'(HEIGHT - 1) && c_q == CW'(WIDTH - 1)) begin
                  state_q <= StDrain;
                  rd_en_q <= 1'b0;
                  drain_q <= '0;
               end else begin
                  rd_addr_q <= rd_addr_q + 1'b1;
                  if (c_q == CW'(WIDTH - 1)) begin
                     c_q <= '0;
                     r_q <= r_q + 1'b1;
                  end else begin
                     c_q <= c_q + 1'b1;
                  end
               end
            end
            // Hold off the border until the last filter result has left the delay line.
            StDrain: begin
               if (drain_q == DW'(FILTER_LAT + 1)) begin
                  state_q  <= StBorder;
                  bphase_q <= BdTop;
                  bside_q  <= 1'b0;
                  c_q      <= '0;
                  baddr_q  <= '0;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            StBorder: begin
               unique case (bphase_q)
                  BdTop, BdBottom: begin
                     if (c_q == CW'(WIDTH - 1)) begin
                        c_q <= '0;
                        if (bphase_q == BdTop) begin
                           bphase_q <= BdBottom;
                           baddr_q  <= ADDR_W'((HEIGHT - 1) * WIDTH);
                        end else begin
                           bphase_q <= BdSide;
                           bside_q  <= 1'b0;
                           r_q      <= RW'(1);
                           baddr_q  <= ADDR_W'(WIDTH);
                        end
                     end else begin
                        c_q     <= c_q + 1'b1;
                        baddr_q <= baddr_q + 1'b1;
                     end
                  end
                  BdSide: begin
                     if (!bside_q) begin
                        bside_q <= 1'b1;
                        baddr_q <= baddr_q + ADDR_W'(WIDTH - 1);
                     end else if (r_q == RW'(HEIGHT - 2)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        bside_q <= 1'b0;
                        r_q     <= r_q + 1'b1;
                        baddr_q <= baddr_q + 1'b1;
                     end
                  end
                  default: bphase_q <= BdTop;
               endcase
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_vld_q  <= 1'b0;
         pix_r_q    <= '0;
         pix_c_q    <= '0;
         pix_addr_q <= '0;
         win_vld_q  <= 1'b0;
         win_addr_q <= '0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
         end
         for (int i = 0; i < FILTER_LAT; i++) begin
            dly_vld_q[i]  <= 1'b0;
            dly_addr_q[i] <= '0;
         end
      end else begin
         pix_vld_q  <= rd_en_q;
         pix_r_q    <= r_q;
         pix_c_q    <= c_q;
         pix_addr_q <= rd_addr_q;
         if (pix_vld_q) begin
            for (int i = 0; i < 3; i++) begin
               win_q[i][0] <= win_q[i][1];
               win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb1[pix_c_q];
            win_q[1][2] <= lb0[pix_c_q];
            win_q[2][2] <= rd_data;
         end
         // Columns 0 and 1 of a row hold the tail of the previous row, so never valid.
         win_vld_q  <= pix_vld_q && pix_r_q >= RW'(2) && pix_c_q >= CW'(2);
         win_addr_q <= (pix_vld_q && pix_r_q >= RW'(2) && pix_c_q >= CW'(2)) ?
                       pix_addr_q - ADDR_W'(WIDTH + 1) : '0;
         dly_vld_q[0]  <= win_vld_q;
         dly_addr_q[0] <= win_addr_q;
         for (int i = 1; i < FILTER_LAT; i++) begin
            dly_vld_q[i]  <= dly_vld_q[i-1];
            dly_addr_q[i] <= dly_addr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pix_vld_q) begin
         lb1[pix_c_q] <= lb0[pix_c_q];
         lb0[pix_c_q] <= rd_data;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign rd_en      = rd_en_q;
   assign rd_addr    = rd_addr_q;
   assign color_data = {win_q[1][1], win_q[1][0], win_q[1][2], win_q[0][1], win_q[2][1],
                        win_q[0][0], win_q[0][2], win_q[2][0], win_q[2][2]};

   always_comb begin
      wr_en   = dly_vld_q[FILTER_LAT-1];
      wr_addr = dly_addr_q[FILTER_LAT-1];
      wr_data = dly_vld_q[FILTER_LAT-1] ? filter_rgb_in : 12'h000;
      if (state_q == StBorder) begin
         wr_en   = 1'b1;
         wr_addr = baddr_q;
         wr_data = 12'h000;
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: 4x4 and 3x3 instances, RAM and filter models, write scoreboard.
module tb_sobel_frame_ctrl;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         start4, busy4, done4, rd_en4, wr_en4;
   logic [3:0]   rd_addr4, wr_addr4;
   logic [11:0]  rd_data4, filt4, wr_data4;
   logic [107:0] cd4;
   logic         start3, busy3, done3, rd_en3, wr_en3;
   logic [3:0]   rd_addr3, wr_addr3;
   logic [11:0]  rd_data3, filt3, wr_data3;
   logic [107:0] cd3;

   sobel_frame_ctrl #(.WIDTH(4), .HEIGHT(4), .ADDR_W(4), .FILTER_LAT(LAT)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
      .rd_addr(rd_addr4), .rd_en(rd_en4), .rd_data(rd_data4), .color_data(cd4),
      .filter_rgb_in(filt4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4));

   sobel_frame_ctrl #(.WIDTH(3), .HEIGHT(3), .ADDR_W(4), .FILTER_LAT(LAT)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
      .rd_addr(rd_addr3), .rd_en(rd_en3), .rd_data(rd_data3), .color_data(cd3),
      .filter_rgb_in(filt3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3));

   logic [11:0] fr4 [16];
   logic [11:0] fr3 [16];
   logic [11:0] fp4 [LAT];
   logic [11:0] fp3 [LAT];
   logic [15:0] q4 [$];
   logic [15:0] q3 [$];

   int checks = 0, errors = 0, cyc = 0;
   int done4_cnt = 0, done3_cnt = 0, wr4_cnt = 0, wr3_cnt = 0, last_wr3_cyc = 0, done3_cyc = 0;

   // Position-weighted stand-in filter: any field swap in color_data changes the result.
   function automatic logic [11:0] filt_fn(input logic [107:0] cd);
      logic [11:0] s;
      s = 12'h000;
      for (int i = 0; i < 9; i++) s = s + 12'(i + 1) * cd[12*i +: 12];
      return s;
   endfunction

   always @(posedge clk) begin
      if (rd_en4) rd_data4 <= fr4[rd_addr4];
      if (rd_en3) rd_data3 <= fr3[rd_addr3];
      fp4[0] <= filt_fn(cd4);
      fp3[0] <= filt_fn(cd3);
      for (int i = 1; i < LAT; i++) begin
         fp4[i] <= fp4[i-1];
         fp3[i] <= fp3[i-1];
      end
   end
   assign filt4 = fp4[LAT-1];
   assign filt3 = fp3[LAT-1];

   always @(negedge clk) begin
      logic [15:0] e;
      cyc = cyc + 1;
      if (wr_en4) begin
         wr4_cnt++;
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL wr4_unexpected got addr %0d data %h, required no write", wr_addr4, wr_data4);
         end else begin
            e = q4.pop_front();
            if ({wr_addr4, wr_data4} !== e) begin
               errors++;
               $display("FAIL wr4_seq got addr %0d data %h, required addr %0d data %h",
                        wr_addr4, wr_data4, e[15:12], e[11:0]);
            end
         end
      end
      if (wr_en3) begin
         wr3_cnt++;
         last_wr3_cyc = cyc;
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL wr3_unexpected got addr %0d data %h, required no write", wr_addr3, wr_data3);
         end else begin
            e = q3.pop_front();
            if ({wr_addr3, wr_data3} !== e) begin
               errors++;
               $display("FAIL wr3_seq got addr %0d data %h, required addr %0d data %h",
                        wr_addr3, wr_data3, e[15:12], e[11:0]);
            end
         end
      end
      if (done4) done4_cnt++;
      if (done3) begin
         done3_cnt++;
         done3_cyc = cyc;
      end
   end

   function automatic logic [11:0] px(input int sel, input int r, input int c);
      return (sel == 4) ? fr4[4'(r * 4 + c)] : fr3[4'(r * 3 + c)];
   endfunction

   task automatic sb_push(input int sel, input logic [15:0] e);
      if (sel == 4) q4.push_back(e);
      else q3.push_back(e);
   endtask

   // Expected write order for one frame: interior in raster order, then the border walk.
   task automatic build_expected(input int sel);
      logic [107:0] cd;
      int n;
      n = sel;
      for (int r = 1; r < n - 1; r++) begin
         for (int c = 1; c < n - 1; c++) begin
            cd = {px(sel, r, c), px(sel, r, c - 1), px(sel, r, c + 1), px(sel, r - 1, c),
                  px(sel, r + 1, c), px(sel, r - 1, c - 1), px(sel, r - 1, c + 1),
                  px(sel, r + 1, c - 1), px(sel, r + 1, c + 1)};
            sb_push(sel, {4'(r * n + c), filt_fn(cd)});
         end
      end
      for (int c = 0; c < n; c++) sb_push(sel, {4'(c), 12'h000});
      for (int c = 0; c < n; c++) sb_push(sel, {4'((n - 1) * n + c), 12'h000});
      for (int r = 1; r < n - 1; r++) begin
         sb_push(sel, {4'(r * n), 12'h000});
         sb_push(sel, {4'(r * n + n - 1), 12'h000});
      end
   endtask

   task automatic wait_done4(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (done4) ok = 1'b1;
      end
   endtask

   task automatic pulse_start4();
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
   endtask

   task automatic clear_counts();
      done4_cnt = 0;
      wr4_cnt   = 0;
   endtask

   task automatic check_frame_end(input string name, input int ndone, input int nwr);
      repeat (3) @(negedge clk);
      checks++;
      if (done4_cnt !== ndone) begin
         errors++;
         $display("FAIL %s_done_count got %0d, required %0d", name, done4_cnt, ndone);
      end
      checks++;
      if (wr4_cnt !== nwr) begin
         errors++;
         $display("FAIL %s_write_count got %0d, required %0d", name, wr4_cnt, nwr);
      end
      checks++;
      if (q4.size() !== 0) begin
         errors++;
         $display("FAIL %s_missing_writes got %0d outstanding, required 0", name, q4.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start4 = 1'b0;
      start3 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy4, done4, rd_en4, wr_en4} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl4 got %b, required 0000", {busy4, done4, rd_en4, wr_en4});
      end
      checks++;
      if ({rd_addr4, wr_addr4, wr_data4, cd4} !== '0) begin
         errors++;
         $display("FAIL reset_data4 got %h %h %h %h, required all zero",
                  rd_addr4, wr_addr4, wr_data4, cd4);
      end
      checks++;
      if ({busy3, done3, rd_en3, wr_en3, rd_addr3, wr_addr3, wr_data3, cd3} !== '0) begin
         errors++;
         $display("FAIL reset_dut3 got busy %b rd_en %b wr_en %b cd %h, required zeros",
                  busy3, rd_en3, wr_en3, cd3);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame(input string name, input int pattern);
      bit ok;
      for (int i = 0; i < 16; i++)
         fr4[i] = (pattern == 0) ? 12'h888 : ((i >= 8) ? 12'hFFF : 12'h000);
      clear_counts();
      build_expected(4);
      pulse_start4();
      checks++;
      if (busy4 !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy got %b, required 1", name, busy4);
      end
      wait_done4(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_done_timeout got no done, required done within 200 cycles", name);
      end
      check_frame_end(name, 1, 16);
   endtask

   task automatic test_timing_ramp();
      bit ok, found;
      logic [107:0] exp_cd;
      exp_cd = {12'd5, 12'd4, 12'd6, 12'd1, 12'd9, 12'd0, 12'd2, 12'd8, 12'd10};
      for (int i = 0; i < 16; i++) fr4[i] = 12'(i);
      clear_counts();
      build_expected(4);
      pulse_start4();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (rd_en4 && rd_addr4 == 4'd10) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL tim_rd10 got no read of addr 10, required one");
      end
      repeat (2) @(negedge clk);
      checks++;
      if (cd4 !== exp_cd) begin
         errors++;
         $display("FAIL tim_color_data got %h, required %h", cd4, exp_cd);
      end
      repeat (LAT) @(negedge clk);
      checks++;
      if ({wr_en4, wr_addr4, wr_data4} !== {1'b1, 4'd5, filt_fn(exp_cd)}) begin
         errors++;
         $display("FAIL tim_first_write got en %b addr %0d data %h, required en 1 addr 5 data %h",
                  wr_en4, wr_addr4, wr_data4, filt_fn(exp_cd));
      end
      wait_done4(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tim_done_timeout got no done, required done");
      end
      check_frame_end("tim", 1, 16);
   endtask

   task automatic test_start_ignored();
      bit ok;
      for (int i = 0; i < 16; i++) fr4[i] = 12'(i * 37 + 5);
      clear_counts();
      build_expected(4);
      pulse_start4();
      repeat (5) @(negedge clk);
      pulse_start4();
      wait_done4(200, ok);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({ok, busy4, rd_en4} !== 3'b100) begin
         errors++;
         $display("FAIL ign_restart got done_seen %b busy %b rd_en %b, required 1 0 0",
                  ok, busy4, rd_en4);
      end
      check_frame_end("ign", 1, 16);
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      for (int i = 0; i < 16; i++) fr4[i] = 12'(16'h0F1 * i);
      clear_counts();
      build_expected(4);
      build_expected(4);
      start4 = 1'b1;
      wait_done4(200, ok1);
      wait_done4(200, ok2);
      start4 = 1'b0;
      checks++;
      if ({ok1, ok2} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_done got %b, required 11", {ok1, ok2});
      end
      check_frame_end("b2b", 2, 32);
      checks++;
      if (busy4 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_busy got %b, required 0", busy4);
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      for (int i = 0; i < 16; i++) fr4[i] = 12'hABC;
      clear_counts();
      pulse_start4();
      repeat (8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({busy4, done4, rd_en4, wr_en4, rd_addr4, wr_addr4, wr_data4, cd4} !== '0) begin
         errors++;
         $display("FAIL abort_reset_outputs got busy %b rd_en %b rd_addr %0d cd %h, required zeros",
                  busy4, rd_en4, rd_addr4, cd4);
      end
      @(negedge clk);
      reset = 1'b0;
      q4.delete();
      @(negedge clk);
      for (int i = 0; i < 16; i++) fr4[i] = 12'(12'h100 + i * 3);
      clear_counts();
      build_expected(4);
      pulse_start4();
      wait_done4(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_done_timeout got no done, required done");
      end
      check_frame_end("abort", 1, 16);
   endtask

   task automatic test_small_3x3();
      bit ok;
      for (int i = 0; i < 16; i++) fr4[i] = 12'h000;
      for (int i = 0; i < 16; i++) fr3[i] = 12'(i * 291 + 17);
      done3_cnt = 0;
      wr3_cnt = 0;
      build_expected(3);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done3) ok = 1'b1;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || done3_cnt !== 1) begin
         errors++;
         $display("FAIL s3_done got seen %b count %0d, required seen 1 count 1", ok, done3_cnt);
      end
      checks++;
      if (wr3_cnt !== 9 || q3.size() !== 0) begin
         errors++;
         $display("FAIL s3_writes got %0d writes %0d outstanding, required 9 and 0",
                  wr3_cnt, q3.size());
      end
      checks++;
      if (done3_cyc !== last_wr3_cyc + 1) begin
         errors++;
         $display("FAIL s3_done_timing got done at %0d last write at %0d, required done 1 after",
                  done3_cyc, last_wr3_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_frame("flat", 0);
      test_frame("split", 1);
      test_timing_ramp();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      test_small_3x3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
